// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and defaults for the systolic array edge feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Default array dimension, operand width and inner-dimension field width
  localparam int DEF_N          = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_K_WIDTH    = 16;

  // Zero-flush length after the last beat: the last operand must cross
  // N-1 lanes of skew plus N-1 PE hops, plus one cycle to accumulate.
  localparam int DEF_FLUSH_LEN  = 2 * DEF_N - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } feeder_state_e;

  // Flush length for an arbitrary array dimension
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : DEPTH-stage register pipeline with reset to zero; DEPTH=0
//               degenerates to a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock and reset have no load on a zero-depth lane
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign data_o         = data_i;
    end else begin : g_shift
      logic [DATA_WIDTH-1:0] pipe_q [DEPTH];

      // Shift operands one stage per cycle; reset flushes any partial job
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < DEPTH; s++) begin
            pipe_q[s] <= '0;
          end
        end else begin
          pipe_q[0] <= data_i;
          for (int s = 1; s < DEPTH; s++) begin
            pipe_q[s] <= pipe_q[s-1];
          end
        end
      end

      assign data_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Feeds A columns / B rows onto the west / north edges of an
//               NxN output-stationary systolic array with diagonal skew,
//               then flushes zeros and pulses done once all PEs are final.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_col,
  input  logic [N*DATA_WIDTH-1:0] b_row,
  output logic [N*DATA_WIDTH-1:0] west_out,
  output logic [N*DATA_WIDTH-1:0] north_out,
  output logic                    busy,
  output logic                    done
);

  localparam int                FLUSH_LEN  = flush_len(N);
  localparam int                FW         = $clog2(FLUSH_LEN + 1);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'(FLUSH_LEN - 1);
  localparam int                LW         = N * DATA_WIDTH;

  feeder_state_e      state_q, state_d;
  logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic [LW-1:0]      a0_q, a0_d;
  logic [LW-1:0]      b0_q, b0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               beat_accept;
  logic               last_beat;
  logic               flush_end;

  assign beat_accept = (state_q == ST_FEED) && in_valid;
  assign last_beat   = beat_accept && (beat_cnt_q == k_len_q - 1'b1);
  assign flush_end   = (state_q == ST_FLUSH) && (flush_cnt_q == FLUSH_LAST);

  // State and datapath registers; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      k_len_q     <= '0;
      flush_cnt_q <= '0;
      a0_q        <= '0;
      b0_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      k_len_q     <= k_len_d;
      flush_cnt_q <= flush_cnt_d;
      a0_q        <= a0_d;
      b0_q        <= b0_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (k_len != '0)) state_d = ST_FEED;
      ST_FEED:  if (last_beat)              state_d = ST_FLUSH;
      ST_FLUSH: if (flush_end)              state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Counters, lane-0 load and registered status flags
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    k_len_d     = k_len_q;
    flush_cnt_d = flush_cnt_q;
    // Anything other than an accepted beat enters the array as a zero
    // bubble, which adds nothing to any accumulator.
    a0_d        = '0;
    b0_d        = '0;
    if (beat_accept) begin
      a0_d = a_col;
      b0_d = b_row;
    end
    case (state_q)
      ST_IDLE: begin
        if (start && (k_len != '0)) begin
          beat_cnt_d = '0;
          k_len_d    = k_len;
        end
      end
      ST_FEED: begin
        if (beat_accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (last_beat)   flush_cnt_d = '0;
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_end ? '0 : flush_cnt_q + 1'b1;
      end
      default: begin
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
      end
    endcase
    // An empty job completes immediately without ever becoming busy
    done_d = ((state_q == ST_IDLE) && start && (k_len == '0)) || flush_end;
    busy_d = (state_d != ST_IDLE);
  end

  assign in_ready = (state_q == ST_FEED);
  assign busy     = busy_q;
  assign done     = done_q;

  // Lane i sees the lane-0 register through i further stages
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(
        .DEPTH      (i),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_west (
        .clk    (clk),
        .rst    (rst),
        .data_i (a0_q[i*DATA_WIDTH +: DATA_WIDTH]),
        .data_o (west_out[i*DATA_WIDTH +: DATA_WIDTH])
      );
      skew_delay_line #(
        .DEPTH      (i),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_north (
        .clk    (clk),
        .rst    (rst),
        .data_i (b0_q[i*DATA_WIDTH +: DATA_WIDTH]),
        .data_o (north_out[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule
`default_nettype wire
